locked_serial_adder: RTL and testbench

- Parametrised, key-locked, digit-serial adder; next generation of the team's fixed 2-bit locked ripple-carry benchmark.
- Adds WIDTH bits at DIGIT bits per cycle, holding the carry in a flop between digits.
- Each digit slice has three key gates, in the same positions as the 2-bit design: sum, propagate and carry-AND term.
- Key is loaded through a serial shift port; valid/ready handshakes on input and output. Used as a sequential target for attack and deobfuscation benches.

---
 rtl/locked_serial_adder.sv | 142 ++++++++++++++
 tb/tb_locked_serial_adder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/locked_serial_adder.sv
// Key-locked digit-serial adder: WIDTH-bit add at DIGIT bits per cycle, carry held in a flop.
// Three XOR/XNOR key gates per digit; the key is loaded LSB-first through a serial shift port.
module locked_serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2,
  parameter logic [3*(WIDTH/DIGIT)-1:0] KEY_POL = 12'hA5C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_shift_en,
  input  logic             key_si,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned KEYW = 3 * NDIG;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LastDig = CW'(NDIG - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [KEYW-1:0]  r_key;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_key_shift;
  logic             w_last;
  logic [KEYW-1:0]  w_kx;
  logic [2:0]       w_dkx;
  logic [DIGIT-1:0] w_dsum;
  logic             w_dcarry;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_c;
  logic             w_p;
  logic             w_g;
  logic             w_pg;

  assign in_ready    = (r_state == StIdle);
  assign out_valid   = (r_state == StDone);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign w_accept    = in_valid && (r_state == StIdle);
  assign w_key_shift = key_shift_en && (r_state != StRun);
  assign w_last      = (r_cnt == LastDig);

  // A set bit in w_kx means that gate inverts its signal.
  assign w_kx  = r_key ^ KEY_POL;
  assign w_dkx = 3'(w_kx >> (3 * r_cnt));

  // Operands shift right by one digit per cycle, so the active digit is always at the bottom.
  always_comb begin
    w_c    = r_carry;
    w_p    = 1'b0;
    w_g    = 1'b0;
    w_pg   = 1'b0;
    w_dsum = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      w_p = r_a[i] ^ r_b[i];
      w_g = r_a[i] & r_b[i];
      if (i == 0) begin
        w_dsum[i] = w_p ^ w_c ^ w_dkx[0];
        w_c       = w_g | ((w_p & w_c) ^ w_dkx[2]);
      end else if (i == int'(DIGIT) - 1) begin
        w_pg      = w_p ^ w_dkx[1];
        w_dsum[i] = w_pg ^ w_c;
        w_c       = w_g | (w_pg & w_c);
      end else begin
        w_dsum[i] = w_p ^ w_c;
        w_c       = w_g | (w_p & w_c);
      end
    end
    w_dcarry = w_c;
  end

  // Result digits enter at the top and settle into place after NDIG shifts.
  assign w_acc_next = WIDTH'({w_dsum, r_acc} >> DIGIT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_key   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_key_shift) begin
        r_key <= {key_si, r_key[KEYW-1:1]};
      end
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else if (r_state == StRun) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_dcarry;
        r_acc   <= w_acc_next;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_sum  <= w_acc_next;
          r_cout <= w_dcarry;
        end
      end
    end
  end

endmodule

// File: tb/tb_locked_serial_adder.sv
// Directed and randomised bench for locked_serial_adder (WIDTH=8, DIGIT=2).
module tb_locked_serial_adder;

  localparam int NDIG = 4;
  localparam int KEYW = 12;
  localparam logic [11:0] KEY_OK = 12'hA5C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_shift_en = 1'b0;
  logic       key_si = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  locked_serial_adder #(
    .WIDTH  (8),
    .DIGIT  (2),
    .KEY_POL(KEY_OK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_shift_en(key_shift_en),
    .key_si      (key_si),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic load_key(input logic [11:0] k);
    for (int i = 0; i < KEYW; i++) begin
      key_shift_en = 1'b1;
      key_si       = k[i];
      @(posedge clk); #1;
    end
    key_shift_en = 1'b0;
    key_si       = 1'b0;
  endtask

  // Stimulus only: one handshake in, result observed, then acknowledged.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                         output logic [7:0] osum, output logic ocout, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a = ta; b = tb_v; cin = tcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    lat   = n;
    osum  = sum;
    ocout = cout;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
    total++; if (dut.r_key !== 12'h000) begin bad++; $display("FAIL reset_key got=%h exp=000", dut.r_key); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_release got=%b exp=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_correct_key();
    logic [7:0] va [5] = '{8'hA7, 8'hFF, 8'h00, 8'h12, 8'h80};
    logic [7:0] vb [5] = '{8'h5C, 8'h01, 8'h00, 8'h34, 8'h80};
    logic       vc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] es [5] = '{8'h04, 8'h00, 8'h00, 8'h46, 8'h01};
    logic       ec [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] s;
    logic       c;
    int         lat;
    load_key(KEY_OK);
    for (int i = 0; i < 5; i++) begin
      run_add(va[i], vb[i], vc[i], s, c, lat);
      total++; if ({c, s} !== {ec[i], es[i]}) begin
        bad++; $display("FAIL correct_key_%0d got=%b_%h exp=%b_%h", i, c, s, ec[i], es[i]);
      end
      total++; if (lat !== NDIG) begin
        bad++; $display("FAIL latency_%0d got=%0d exp=%0d", i, lat, NDIG);
      end
    end
  endtask

  task automatic test_wrong_key();
    logic [7:0] s;
    logic       c;
    int         lat;
    load_key(12'hA5D);
    run_add(8'hA7, 8'h5C, 1'b1, s, c, lat);
    total++; if ({c, s} !== {1'b1, 8'h05}) begin
      bad++; $display("FAIL wrong_key_sum_gate got=%b_%h exp=1_05", c, s);
    end
    load_key(12'hA58);
    run_add(8'hA7, 8'h5C, 1'b1, s, c, lat);
    total++; if ({c, s} !== {1'b1, 8'h02}) begin
      bad++; $display("FAIL wrong_key_carry_gate got=%b_%h exp=1_02", c, s);
    end
  endtask

  task automatic test_backpressure_freeze();
    int n;
    load_key(KEY_OK);
    a = 8'h3C; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    key_shift_en = 1'b1;
    key_si       = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL run_in_ready got=%b exp=0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    key_shift_en = 1'b0;
    key_si       = 1'b0;
    total++; if (dut.r_key !== KEY_OK) begin
      bad++; $display("FAIL key_frozen_in_run got=%h exp=%h", dut.r_key, KEY_OK);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 10; i++) begin
      total++; if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, 1'b0, 8'h4B}) begin
        bad++;
        $display("FAIL backpressure_hold_%0d got=%b%b_%b_%h exp=10_0_4b", i, out_valid, in_ready,
                 cout, sum);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL release_done got=%b exp=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_shift_on_accept();
    int n;
    for (int i = 0; i < KEYW - 1; i++) begin
      key_shift_en = 1'b1;
      key_si       = KEY_OK[i];
      @(posedge clk); #1;
    end
    // Final key bit shifts on the same edge the operands are accepted.
    key_si = KEY_OK[KEYW-1];
    a = 8'hA7; b = 8'h5C; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    key_shift_en = 1'b0;
    in_valid     = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++; if ({cout, sum} !== {1'b1, 8'h04}) begin
      bad++; $display("FAIL shift_on_accept got=%b_%h exp=1_04", cout, sum);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s;
    logic       c;
    int         lat;
    a = 8'hA7; b = 8'h5C; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if ({out_valid, in_ready, cout, sum} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_mid_run got=%b%b_%b_%h exp=01_0_00", out_valid, in_ready, cout, sum);
    end
    total++; if (dut.r_key !== 12'h000) begin
      bad++; $display("FAIL reset_mid_run_key got=%h exp=000", dut.r_key);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_no_output got=%b exp=0", out_valid);
    end
    load_key(KEY_OK);
    run_add(8'h3C, 8'h0F, 1'b0, s, c, lat);
    total++; if ({c, s} !== {1'b0, 8'h4B}) begin
      bad++; $display("FAIL after_reset_add got=%b_%h exp=0_4b", c, s);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic       acc;
    int         sent;
    int         got;
    int         cyc;
    sent = 0; got = 0; cyc = 0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); in_valid = 1'b1;
    while (got < 1000 && cyc < 40000) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL random_unexpected_result got=%b_%h exp=none", cout, sum);
        end else begin
          e = exp_q.pop_front();
          if ({cout, sum} !== e) begin
            bad++; $display("FAIL random_%0d got=%b_%h exp=%b_%h", got, cout, sum, e[8], e[7:0]);
          end
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {8'h00, cin});
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (sent < 1000) begin
          a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (got < 1000) begin
      total++; bad++;
      $display("FAIL random_timeout got=%0d results exp=1000", got);
    end
  endtask

  initial begin
    test_reset();
    test_correct_key();
    test_wrong_key();
    test_backpressure_freeze();
    test_shift_on_accept();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
